// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Microstate sequencer for a small 8-bit CPU. It fetches an instruction byte
// from bus_in, latches it, and walks through the microstates that belong to
// the instruction class. The control decoder turns the state code into
// datapath control signals (and evaluates jump conditions itself).
//
// Instruction format: class = [7:6], operand2 = [5:3], operand1 = [2:0].
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous active-high reset
//   bus_in     in   8  data bus; RAM output during STATE_FETCH_INST
//   state      out  8  current microstate (STATE_* code)
//   operand2   out  3  latched instruction field [5:3]
//   operand1   out  3  latched instruction field [2:0]
//   halted     out  1  high while in STATE_HALT
//   instr_done out  1  one-cycle pulse in the last microstate of an instruction
//   illegal    out  1  sticky illegal-opcode flag (only with SEQ_ILLEGAL_TRAP_EN)
//
// Configuration macro:
//   SEQ_ILLEGAL_TRAP_EN  defined   : illegal opcode -> STATE_HALT, illegal=1
//                        undefined : illegal opcode is a one-cycle NOP
//
// State codes:
//   00 FETCH_PC   01 FETCH_INST 02 ALU_EXEC  03 ALU_OUT   04 MOV_REG
//   05 SET_REG    06 LOAD_ADDR  07 SET_MEM   08 FETCH_SP  09 STACK_REG
//   0A INC_SP     0B TMP_JUMP   0C JUMP      0D RET       0E HALT
// ---------------------------------------------------------------------------
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_in,
  output logic [7:0] state,
  output logic [2:0] operand2,
  output logic [2:0] operand1,
  output logic       halted,
  output logic       instr_done
`ifdef SEQ_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [7:0] {
    STATE_FETCH_PC   = 8'h00,
    STATE_FETCH_INST = 8'h01,
    STATE_ALU_EXEC   = 8'h02,
    STATE_ALU_OUT    = 8'h03,
    STATE_MOV_REG    = 8'h04,
    STATE_SET_REG    = 8'h05,
    STATE_LOAD_ADDR  = 8'h06,
    STATE_SET_MEM    = 8'h07,
    STATE_FETCH_SP   = 8'h08,
    STATE_STACK_REG  = 8'h09,
    STATE_INC_SP     = 8'h0A,
    STATE_TMP_JUMP   = 8'h0B,
    STATE_JUMP       = 8'h0C,
    STATE_RET        = 8'h0D,
    STATE_HALT       = 8'h0E
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_JMP = 2'b11;

  // class 10 operand2 codes
  localparam logic [2:0] OP_SET   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  // class 11 operand2 codes (000..100 are plain jumps)
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] opcode_q;
  // step_q is 0 during the instruction fetch phase (FETCH_PC/FETCH_INST)
  // and holds the 1-based index of the current execute microstate
  // afterwards. That is what tells the instruction-fetch FETCH_PC apart
  // from an operand-fetch FETCH_PC, and orders repeated visits.
  logic [1:0] step_q, step_d;
  logic       halt_seen_q;   // HALT already pulsed instr_done
  logic       done;
  logic       set_illegal;

  logic [1:0] cls_q, cls_bus;
  logic [2:0] op2_q, op2_bus;
  logic       bus_illegal;

  assign cls_q   = opcode_q[7:6];
  assign op2_q   = opcode_q[5:3];
  assign cls_bus = bus_in[7:6];
  assign op2_bus = bus_in[5:3];

  // Only class 10 has unused operand2 codes (101..111).
  assign bus_illegal = (cls_bus == CLS_MEM) && (op2_bus > OP_POP);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_FETCH_PC;
      opcode_q    <= 8'h00;
      step_q      <= 2'd0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      halt_seen_q <= (state_q == STATE_HALT);
      if (state_q == STATE_FETCH_INST)
        opcode_q <= bus_in;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (set_illegal)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`endif

  // -------------------------------------------------------------------------
  // Next state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    done        = 1'b0;
    set_illegal = 1'b0;

    unique case (state_q)
      STATE_FETCH_PC: begin
        if (step_q == 2'd0) begin
          // instruction fetch: address goes out, byte arrives next cycle
          state_d = STATE_FETCH_INST;
        end else begin
          // operand fetch inside class 10 / 11 instructions
          step_d  = step_q + 2'd1;
          state_d = STATE_FETCH_PC;
          if (cls_q == CLS_MEM) begin
            case (op2_q)
              OP_SET:            state_d = STATE_SET_REG;
              OP_LOAD, OP_STORE: state_d = STATE_LOAD_ADDR;
              default: begin
                state_d = STATE_FETCH_PC;
                step_d  = 2'd0;
              end
            endcase
          end else if (cls_q == CLS_JMP) begin
            state_d = (op2_q == OP_CALL) ? STATE_FETCH_SP : STATE_JUMP;
          end else begin
            state_d = STATE_FETCH_PC;
            step_d  = 2'd0;
          end
        end
      end

      STATE_FETCH_INST: begin
        // Decode straight from the bus; the opcode register loads on the
        // same edge, so later states read the latched copy.
        step_d = 2'd1;
        case (cls_bus)
          CLS_ALU: state_d = STATE_ALU_EXEC;
          CLS_MOV: state_d = STATE_MOV_REG;
          CLS_MEM: begin
            case (op2_bus)
              OP_SET, OP_LOAD, OP_STORE: state_d = STATE_FETCH_PC;
              OP_PUSH:                   state_d = STATE_FETCH_SP;
              OP_POP:                    state_d = STATE_INC_SP;
              default:                   state_d = STATE_FETCH_PC;
            endcase
          end
          default: begin
            case (op2_bus)
              OP_RET:  state_d = STATE_INC_SP;
              OP_HALT: state_d = STATE_HALT;
              default: state_d = STATE_FETCH_PC;   // jumps and CALL
            endcase
          end
        endcase

        if (bus_illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d     = STATE_HALT;
          set_illegal = 1'b1;
`else
          // one-cycle NOP: this fetch cycle is the whole instruction
          state_d = STATE_FETCH_PC;
          done    = 1'b1;
`endif
        end

        if (state_d == STATE_HALT || state_d == STATE_FETCH_PC && bus_illegal)
          step_d = 2'd0;
      end

      STATE_ALU_EXEC: begin
        state_d = STATE_ALU_OUT;
        step_d  = step_q + 2'd1;
      end

      STATE_LOAD_ADDR: begin
        state_d = (op2_q == OP_LOAD) ? STATE_SET_REG : STATE_SET_MEM;
        step_d  = step_q + 2'd1;
      end

      STATE_INC_SP: begin
        state_d = STATE_FETCH_SP;
        step_d  = step_q + 2'd1;
      end

      STATE_FETCH_SP: begin
        step_d  = step_q + 2'd1;
        state_d = STATE_FETCH_PC;
        if (cls_q == CLS_MEM) begin
          state_d = (op2_q == OP_PUSH) ? STATE_STACK_REG : STATE_SET_REG;
        end else if (cls_q == CLS_JMP) begin
          state_d = (op2_q == OP_CALL) ? STATE_TMP_JUMP : STATE_RET;
        end else begin
          step_d = 2'd0;
        end
      end

      // last microstate of every non-HALT instruction
      STATE_ALU_OUT, STATE_MOV_REG, STATE_SET_REG, STATE_SET_MEM,
      STATE_STACK_REG, STATE_TMP_JUMP, STATE_JUMP, STATE_RET: begin
        state_d = STATE_FETCH_PC;
        step_d  = 2'd0;
        done    = 1'b1;
      end

      STATE_HALT: begin
        // absorbing; pulse done only on the first cycle here
        state_d = STATE_HALT;
        step_d  = 2'd0;
        done    = !halt_seen_q;
      end

      default: begin
        state_d = STATE_FETCH_PC;
        step_d  = 2'd0;
      end
    endcase
  end

  assign state      = state_q;
  assign operand2   = opcode_q[5:3];
  assign operand1   = opcode_q[2:0];
  assign halted     = (state_q == STATE_HALT);
  // a reset cycle never reports a completed instruction
  assign instr_done = done & ~rst;

endmodule
